// File: rtl/cu_pkg.sv
// Shared types and constants for the CU instruction issuer.
// Instruction field layout and FSM state encoding.
package cu_pkg;

    localparam int INSTR_W = 48;
    localparam int DATA_W  = 128;

    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] dst;
        logic [2:0] src;
        logic [8:0] opa;
        logic [8:0] opb;
        logic [8:0] opc;
        logic [8:0] opd;
        logic [2:0] rsvd;
    } cu_instr_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } cu_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty decode.
// A write while full is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd    = rd_en && !empty;
    assign do_wr    = wr_en && (!full || do_rd);
    assign overflow = wr_en && full && !do_rd;
    assign rd_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/cu_instr_issuer.sv
// Issues queued instructions to the CU one at a time and captures
// the CU register bus a fixed number of cycles after each issue.
module cu_instr_issuer #(
    parameter int DEPTH          = 8,
    parameter int RESULT_LATENCY = 1,
    parameter int INSTR_W        = 48,
    parameter int DATA_W         = 128
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic [INSTR_W-1:0] WR_DATA,
    output logic               FULL,
    output logic               EMPTY,
    input  logic               RUN,
    output logic [INSTR_W-1:0] INSTRUCTION,
    output logic               INSTR_VALID,
    input  logic [DATA_W-1:0]  REGISTER_OUTPUT_DATA_BUS,
    output logic [DATA_W-1:0]  RESULT,
    output logic               RESULT_VALID,
    output logic               BUSY,
    output logic [7:0]         ISSUE_COUNT,
    output logic               ERR_OVERFLOW
);
    import cu_pkg::*;

    localparam int CW = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(RESULT_LATENCY - 1);

    cu_state_t          state;
    logic [CW-1:0]      wait_cnt;
    logic [INSTR_W-1:0] head;
    logic               pop;
    logic               overflow;

    assign pop  = (state == IDLE) && RUN && !EMPTY;
    assign BUSY = (state != IDLE);

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr_en    (WR_EN),
        .wr_data  (WR_DATA),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (FULL),
        .empty    (EMPTY),
        .overflow (overflow)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            INSTRUCTION  <= INSTR_W'(NOP);
            INSTR_VALID  <= 1'b0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
            ISSUE_COUNT  <= '0;
            ERR_OVERFLOW <= 1'b0;
        end else begin
            INSTR_VALID  <= 1'b0;
            RESULT_VALID <= 1'b0;
            if (overflow) ERR_OVERFLOW <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        INSTRUCTION <= head;
                        INSTR_VALID <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    // capture on the last held cycle, then drop to NOP
                    if (wait_cnt == '0) begin
                        RESULT       <= REGISTER_OUTPUT_DATA_BUS;
                        ISSUE_COUNT  <= ISSUE_COUNT + 8'd1;
                        INSTRUCTION  <= INSTR_W'(NOP);
                        RESULT_VALID <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cu_instr_issuer.sv
// Directed bench for cu_instr_issuer: one instance with latency 1,
// one with latency 4, sharing clock and reset.
module tb_cu_instr_issuer;

    localparam logic [79:0] HI1 = 80'hDEAD_0000_0000_0000_0001;
    localparam logic [79:0] HI4 = 80'hBEEF_0000_0000_0000_0004;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [47:0]  wr_data = '0;
    logic         run = 1'b0;
    logic         w4_en = 1'b0;
    logic [47:0]  w4_data = '0;
    logic         run4 = 1'b0;

    logic         full1, empty1, iv1, rv1, busy1, err1;
    logic [47:0]  instr1;
    logic [127:0] bus1, res1;
    logic [7:0]   cnt1;

    logic         full4, empty4, iv4, rv4, busy4, err4;
    logic [47:0]  instr4;
    logic [127:0] bus4, res4;
    logic [7:0]   cnt4;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [127:0] res1_q[$];
    int           cyc1_q[$];
    logic [127:0] res4_q[$];

    // CU stand-in: register contents reflect the instruction being held
    assign bus1 = {HI1, instr1};
    assign bus4 = {HI4, instr4};

    always #5 clk = ~clk;

    cu_instr_issuer #(.DEPTH(8), .RESULT_LATENCY(1)) dut1 (
        .CLK                      (clk),
        .RST                      (rst),
        .WR_EN                    (wr_en),
        .WR_DATA                  (wr_data),
        .FULL                     (full1),
        .EMPTY                    (empty1),
        .RUN                      (run),
        .INSTRUCTION              (instr1),
        .INSTR_VALID              (iv1),
        .REGISTER_OUTPUT_DATA_BUS (bus1),
        .RESULT                   (res1),
        .RESULT_VALID             (rv1),
        .BUSY                     (busy1),
        .ISSUE_COUNT              (cnt1),
        .ERR_OVERFLOW             (err1)
    );

    cu_instr_issuer #(.DEPTH(8), .RESULT_LATENCY(4)) dut4 (
        .CLK                      (clk),
        .RST                      (rst),
        .WR_EN                    (w4_en),
        .WR_DATA                  (w4_data),
        .FULL                     (full4),
        .EMPTY                    (empty4),
        .RUN                      (run4),
        .INSTRUCTION              (instr4),
        .INSTR_VALID              (iv4),
        .REGISTER_OUTPUT_DATA_BUS (bus4),
        .RESULT                   (res4),
        .RESULT_VALID             (rv4),
        .BUSY                     (busy4),
        .ISSUE_COUNT              (cnt4),
        .ERR_OVERFLOW             (err4)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (rv1) begin
                res1_q.push_back(res1);
                cyc1_q.push_back(cyc);
            end
            if (rv4) res4_q.push_back(res4);
        end
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        run   = 1'b0;
        w4_en = 1'b0;
        run4  = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        res1_q.delete();
        cyc1_q.delete();
        res4_q.delete();
    endtask

    task automatic push1(input logic [47:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push4(input logic [47:0] d);
        w4_en   = 1'b1;
        w4_data = d;
        tick();
        w4_en = 1'b0;
    endtask

    initial begin
        int bad;
        do_reset();

        // reset state
        check("rst_instr", instr1, 0);
        check("rst_empty", empty1, 1);
        check("rst_full", full1, 0);
        check("rst_busy", busy1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_result", res1, 0);

        // reset while in WAIT
        push1(48'h1111_2222_3333);
        check("push_empty", empty1, 0);
        run = 1'b1;
        tick();
        tick();
        check("pre_rst_busy", busy1, 1);
        rst = 1'b1;
        #1;
        check("arst_instr", instr1, 0);
        check("arst_iv", iv1, 0);
        check("arst_busy", busy1, 0);
        check("arst_empty", empty1, 1);
        check("arst_rv", rv1, 0);
        run = 1'b0;
        tick();
        rst = 1'b0;
        run_cycles(6);
        check("arst_no_rv", res1_q.size(), 0);

        // single issue, latency 1
        do_reset();
        push1(48'h0A03_00C0_2020);
        run = 1'b1;
        tick();
        run = 1'b0;
        check("s_instr0", instr1, 48'h0A03_00C0_2020);
        check("s_iv0", iv1, 1);
        check("s_busy", busy1, 1);
        tick();
        check("s_instr1", instr1, 48'h0A03_00C0_2020);
        check("s_iv1", iv1, 0);
        check("s_rv1", rv1, 0);
        tick();
        check("s_rv2", rv1, 1);
        check("s_result", res1, {HI1, 48'h0A03_00C0_2020});
        check("s_cnt", cnt1, 1);
        check("s_instr_nop", instr1, 0);
        tick();
        check("s_rv3", rv1, 0);
        check("s_idle", busy1, 0);
        check("s_hold", res1, {HI1, 48'h0A03_00C0_2020});

        // back-to-back
        do_reset();
        push1(48'hB000_0000_0000);
        push1(48'hB000_0000_0001);
        push1(48'hB000_0000_0002);
        run = 1'b1;
        run_cycles(16);
        check("b2b_n", res1_q.size(), 3);
        if (res1_q.size() == 3) begin
            for (int i = 0; i < 3; i++)
                check("b2b_val", res1_q[i], {HI1, 48'hB000_0000_0000 + 48'(i)});
            check("b2b_gap1", cyc1_q[1] - cyc1_q[0], 4);
            check("b2b_gap2", cyc1_q[2] - cyc1_q[1], 4);
        end
        check("b2b_cnt", cnt1, 3);
        check("b2b_empty", empty1, 1);

        // fill, overflow, drain
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push1(48'hC000_0000_0000 + 48'(i));
            if (i == 7) begin
                check("f_full8", full1, 1);
                check("f_err8", err1, 0);
            end
        end
        check("f_err9", err1, 1);
        check("f_full9", full1, 1);
        run = 1'b1;
        run_cycles(40);
        check("f_n", res1_q.size(), 8);
        bad = 0;
        foreach (res1_q[i])
            if (res1_q[i] !== {HI1, 48'hC000_0000_0000 + 48'(i)}) bad++;
        check("f_order", bad, 0);
        check("f_empty", empty1, 1);
        check("f_cnt", cnt1, 8);
        check("f_err_sticky", err1, 1);

        // pop and write on the same edge while full
        do_reset();
        for (int i = 0; i < 8; i++)
            push1(48'hD000_0000_0000 + 48'(i));
        check("pw_full_pre", full1, 1);
        wr_en   = 1'b1;
        wr_data = 48'hD000_0000_0008;
        run     = 1'b1;
        tick();
        wr_en = 1'b0;
        check("pw_full", full1, 1);
        check("pw_err", err1, 0);
        check("pw_iv", iv1, 1);
        run_cycles(44);
        check("pw_n", res1_q.size(), 9);
        if (res1_q.size() == 9) begin
            check("pw_first", res1_q[0], {HI1, 48'hD000_0000_0000});
            check("pw_last", res1_q[8], {HI1, 48'hD000_0000_0008});
        end

        // latency 4, RUN dropped during WAIT
        do_reset();
        push4(48'hE000_0000_0000);
        push4(48'hE000_0000_0001);
        run4 = 1'b1;
        tick();
        run4 = 1'b0;
        check("l4_instr", instr4, 48'hE000_0000_0000);
        check("l4_iv", iv4, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("l4_held", instr4, 48'hE000_0000_0000);
            check("l4_no_rv", rv4, 0);
        end
        tick();
        check("l4_rv", rv4, 1);
        check("l4_result", res4, {HI4, 48'hE000_0000_0000});
        check("l4_nop", instr4, 0);
        run_cycles(10);
        check("l4_no_issue", res4_q.size(), 0);
        check("l4_idle", busy4, 0);
        check("l4_pending", empty4, 0);
        check("l4_cnt", cnt4, 1);
        run4 = 1'b1;
        run_cycles(10);
        check("l4_n2", res4_q.size(), 1);
        if (res4_q.size() == 1)
            check("l4_second", res4_q[0], {HI4, 48'hE000_0000_0001});
        check("l4_cnt2", cnt4, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cu_instr_issuer.md
Name: cu_instr_issuer

Overview:
Initiator side of the CU instruction interface. A host loads 48-bit instructions into an internal FIFO. The block issues them one at a time on INSTRUCTION and holds each one stable while the CU computes. After a fixed latency it captures the CU's 128-bit REGISTER_OUTPUT_DATA_BUS into RESULT. It sits between host/program load logic and CU, replacing hand-driven stimulus.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2.
RESULT_LATENCY, 1, cycles INSTRUCTION is held before capture; minimum 1.
INSTR_W, 48, instruction width.
DATA_W, 128, CU register output bus width.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, asynchronous, active-high.
WR_EN  in  1  push WR_DATA into FIFO.
WR_DATA  in  48  instruction to enqueue.
FULL  out  1  FIFO holds DEPTH entries.
EMPTY  out  1  FIFO holds 0 entries.
RUN  in  1  permission to issue the next instruction.
INSTRUCTION  out  48  instruction to CU; 48'h0 (NOP) when not issuing.
INSTR_VALID  out  1  high in the cycle a new instruction is first driven.
REGISTER_OUTPUT_DATA_BUS  in  128  CU register contents.
RESULT  out  128  captured CU output.
RESULT_VALID  out  1  one-cycle pulse when RESULT updates.
BUSY  out  1  state is not IDLE.
ISSUE_COUNT  out  8  completed instructions; wraps 255->0.
ERR_OVERFLOW  out  1  sticky: a write was attempted while full.

Behaviour:
- Reset (async, any state): FIFO emptied (pointers 0), state IDLE, INSTRUCTION=0, INSTR_VALID=0, RESULT=0, RESULT_VALID=0, ISSUE_COUNT=0, ERR_OVERFLOW=0, BUSY=0, EMPTY=1, FULL=0. An in-flight instruction is abandoned and produces no result.
- FIFO: registered read/write pointers, each log2(DEPTH)+1 bits wide. FULL and EMPTY are decoded from the registered pointers.
  - A write while FULL is dropped and sets ERR_OVERFLOW, unless a pop occurs on the same edge; in that case the write is accepted.
  - A write to an empty FIFO is visible (EMPTY=0) on the following cycle. It is not issuable in its own write cycle.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if RUN && !EMPTY, on the next edge INSTRUCTION <= FIFO head, pop, go to ISSUE. Otherwise stay in IDLE with INSTRUCTION=0.
  - ISSUE (1 cycle): INSTR_VALID=1; load the wait counter with RESULT_LATENCY-1; go to WAIT.
  - WAIT (RESULT_LATENCY cycles): INSTRUCTION is held stable. When the counter reaches 0, on that edge: RESULT <= REGISTER_OUTPUT_DATA_BUS, ISSUE_COUNT++, INSTRUCTION <= 0, go to DONE.
  - DONE (1 cycle): RESULT_VALID=1; go to IDLE.
- Timing: with RUN high and the FIFO non-empty in IDLE, RESULT_VALID is high exactly RESULT_LATENCY+2 edges later. Issue period is RESULT_LATENCY+3 cycles per instruction.
- If RUN deasserts mid-operation, the current instruction completes normally; no new issue occurs until RUN is high again in IDLE.
- WR_EN is honoured in every state, including while an instruction is in flight.
- RESULT holds its value until the next capture.

Decomposition:
- Package cu_pkg holds:
  - INSTR_W=48, DATA_W=128.
  - Field slices: OPCODE [47:45], DST [44:42], SRC [41:39], OPA [38:30], OPB [29:21], OPC [20:12], OPD [11:3], RSVD [2:0].
  - NOP=48'h0.
  - The FSM state enum.
- One sub-module: sync_fifo (parameterised by width and depth) provides the FIFO storage and FULL/EMPTY flags. The FSM stays in the top level.

Test Plan:
- Reset mid-WAIT: push one instruction, set RUN, assert RST during WAIT -> all outputs at reset values immediately, EMPTY=1, no RESULT_VALID pulse afterwards.
- Single issue, RESULT_LATENCY=1: push 48'h0A03_00C0_2020, set RUN, model drives bus 128'hDEAD...0001 -> INSTRUCTION=0A0300C02020 for 2 cycles, INSTR_VALID pulses once, RESULT_VALID 3 edges after RUN is sampled, RESULT=bus value, ISSUE_COUNT=1, INSTRUCTION returns to 0.
- Back-to-back: push 3 instructions, hold RUN -> 3 results spaced 4 cycles apart, in FIFO order, ISSUE_COUNT=3, EMPTY=1 at the end.
- Full/overflow, DEPTH=8: 9 writes with RUN=0 -> FULL=1 after the 8th, 9th dropped, ERR_OVERFLOW=1; then run all 8 -> exactly 8 results.
- Simultaneous pop and write while FULL -> write accepted, FULL stays 1, ERR_OVERFLOW stays 0.
- RUN dropped during WAIT with RESULT_LATENCY=4 -> current result still delivered; no further issue until RUN is reasserted.
